alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
Clocked initiator that drives the team's combinational ALU (4-bit operands a/b, 2-bit sel, 4-bit alu_out).
- Accepts operation commands over a valid/ready handshake.
- Drives registered, stable operands and sel to the ALU and waits a fixed settle time.
- Captures alu_out and returns it over a valid/ready result channel.
- Supports chaining: the previous result can be used as operand a.

Parameters:
WIDTH, 4, operand/result width (matches ALU a, b, alu_out).
SEL_W, 2, ALU select width.
SETTLE_CYCLES, 1, cycles operands are held before alu_out is sampled (>=1).
COUNT_W, 8, width of the completed-operation counter.

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at clk edge
cmd_a  in  WIDTH  operand a (ignored when cmd_chain=1)
cmd_b  in  WIDTH  operand b
cmd_sel  in  SEL_W  ALU select, passed through unmodified
cmd_chain  in  1  1 = use last captured result as operand a
alu_a  out  WIDTH  to ALU a
alu_b  out  WIDTH  to ALU b
alu_sel  out  SEL_W  to ALU sel
alu_out  in  WIDTH  from ALU alu_out
res_valid  out  1  result present
res_ready  in  1  result consumed when res_valid && res_ready at clk edge
res_data  out  WIDTH  captured result
busy  out  1  state != IDLE
op_count  out  COUNT_W  number of results consumed, wraps

Behaviour:
- Reset: one clock; rst is asynchronous and active-high.
  - Asserting rst forces state=IDLE and sets alu_a, alu_b, alu_sel, res_data, last_result and op_count to 0, res_valid=0, busy=0.
  - cmd_ready=0 while rst=1.
- FSM states: IDLE, DRIVE, RESP.
- IDLE:
  - cmd_ready=1.
  - On accept: alu_a <= cmd_chain ? last_result : cmd_a; alu_b <= cmd_b; alu_sel <= cmd_sel; settle counter <= SETTLE_CYCLES-1; go to DRIVE.
- DRIVE:
  - cmd_ready=0. ALU outputs are held.
  - When the counter reaches 0: res_data <= alu_out; last_result <= alu_out; res_valid <= 1; go to RESP. Otherwise decrement the counter.
- RESP:
  - res_valid=1. res_data is stable until consumed.
  - cmd_ready = res_ready (combinational).
  - On res_ready: op_count += 1 (mod 2^COUNT_W).
  - If cmd_valid is also high, accept the new command exactly as in IDLE and go directly to DRIVE. In that case, chaining uses the result being handed off in the same cycle.
  - Otherwise go to IDLE and clear res_valid.
- Latency: with the accept at edge t, res_valid is visible after edge t+SETTLE_CYCLES. Sustained back-to-back throughput is one op per SETTLE_CYCLES+1 cycles.
- Hold rule: alu_a, alu_b and alu_sel change only on an accept edge, never mid-op. They keep their last value while in IDLE.
- Arithmetic: the block performs no arithmetic on data. alu_out is captured at full WIDTH with no extension. op_count wraps from 2^COUNT_W-1 to 0.
- Backpressure: res_ready=0 holds RESP indefinitely. No command is accepted while holding.
- Reset mid-operation: the pending op is dropped with no result. A following chained command uses a=0.
- cmd_chain after reset, with no op yet completed: a=0.

Decomposition:
- Shared package alu_pkg:
  - WIDTH/SEL_W defaults.
  - State enum typedef: IDLE, DRIVE, RESP.
  - Operand typedef logic [WIDTH-1:0].
  - Sel typedef logic [SEL_W-1:0].
- No sub-module; the settle counter is inline.
- Bench instantiates the existing ALU. Checks below use a bench stub with alu_out=(alu_a+alu_b) mod 16 for all sel, so results are sel-independent.

Test Plan:
1. Reset: rst=1 mid-cycle (async) -> all outputs 0 immediately, cmd_ready=0. Release rst -> cmd_ready=1, busy=0.
2. Single op, SETTLE_CYCLES=1: a=0111, b=0001, sel=10, chain=0, accepted at edge t.
   - After edge t: alu_a=0111, alu_b=0001, alu_sel=10, busy=1.
   - After edge t+1: res_valid=1, res_data=1000.
   - With res_ready=1: op_count=1.
3. Backpressure: complete an op, hold res_ready=0 for 5 cycles with cmd_valid=1 -> res_valid held, res_data stable, cmd_ready=0, alu_* unchanged. Raise res_ready -> both the handoff and the new accept occur in the same cycle.
4. Chain back-to-back: cmd1 a=0101, b=0011 -> res 1000. cmd2 chain=1, b=0110, presented with res_ready=1 -> alu_a=1000, res 1110, op_count=2.
5. Wrap: a=1111, b=0001 -> res_data=0000. Preload via 256 consumed ops -> op_count returns to 0.
6. Reset mid-op: rst pulsed during DRIVE -> no res_valid. Next cmd chain=1, b=0011 -> alu_a=0000, res 0011.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and defaults for the ALU operation sequencer.
package alu_pkg;

  localparam int ALU_WIDTH = 4;
  localparam int ALU_SEL_W = 2;

  // Sequencer FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    RESP  = 2'd2
  } seq_state_t;

  typedef logic [ALU_WIDTH-1:0] operand_t;
  typedef logic [ALU_SEL_W-1:0] sel_t;

endpackage

// File: rtl/alu_op_sequencer.sv
// Clocked initiator for the combinational ALU: accepts a command, holds
// registered operands for a fixed settle time, captures alu_out and hands the
// result back over a valid/ready channel. The last captured result can be
// reused as operand a (chaining).
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH         = ALU_WIDTH,
  parameter int SEL_W         = ALU_SEL_W,
  parameter int SETTLE_CYCLES = 1,
  parameter int COUNT_W       = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [WIDTH-1:0]   cmd_a,
  input  logic [WIDTH-1:0]   cmd_b,
  input  logic [SEL_W-1:0]   cmd_sel,
  input  logic               cmd_chain,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  output logic [SEL_W-1:0]   alu_sel,
  input  logic [WIDTH-1:0]   alu_out,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [WIDTH-1:0]   res_data,
  output logic               busy,
  output logic [COUNT_W-1:0] op_count
);

  // Settle counter only needs to hold SETTLE_CYCLES-1.
  localparam int CNT_W = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  seq_state_t       state;
  logic [CNT_W-1:0] settle;
  logic [WIDTH-1:0] last_result;
  logic             accept;

  // Command handshake: always open in IDLE, open in RESP only while the
  // current result is being consumed, closed during reset and DRIVE.
  always_comb begin
    cmd_ready = 1'b0;
    if (rst) begin
      cmd_ready = 1'b0;
    end else begin
      case (state)
        IDLE:    cmd_ready = 1'b1;
        RESP:    cmd_ready = res_ready;
        default: cmd_ready = 1'b0;
      endcase
    end
  end

  assign accept = cmd_valid && cmd_ready;
  assign busy   = (state != IDLE);

  // Sequencer FSM with registered ALU drive, result capture and op counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      settle      <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_sel     <= '0;
      res_data    <= '0;
      last_result <= '0;
      res_valid   <= 1'b0;
      op_count    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            alu_a   <= cmd_chain ? last_result : cmd_a;
            alu_b   <= cmd_b;
            alu_sel <= cmd_sel;
            settle  <= SETTLE_LOAD;
            state   <= DRIVE;
          end
        end
        DRIVE: begin
          if (settle == '0) begin
            res_data    <= alu_out;
            last_result <= alu_out;
            res_valid   <= 1'b1;
            state       <= RESP;
          end else begin
            settle <= settle - CNT_W'(1);
          end
        end
        RESP: begin
          if (res_ready) begin
            op_count  <= op_count + COUNT_W'(1);
            res_valid <= 1'b0;
            if (cmd_valid) begin
              // last_result already equals the result being handed off.
              alu_a   <= cmd_chain ? last_result : cmd_a;
              alu_b   <= cmd_b;
              alu_sel <= cmd_sel;
              settle  <= SETTLE_LOAD;
              state   <= DRIVE;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state     <= IDLE;
          res_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer using an adder stub as the ALU.
module tb_alu_op_sequencer;

  localparam int SETTLE = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [3:0] cmd_a = 4'd0;
  logic [3:0] cmd_b = 4'd0;
  logic [1:0] cmd_sel = 2'd0;
  logic       cmd_chain = 1'b0;
  logic [3:0] alu_a, alu_b, alu_out, res_data;
  logic [1:0] alu_sel;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic       busy;
  logic [7:0] op_count;

  logic [7:0] exp_count = 8'd0;
  int passed = 0;
  int total  = 0;

  // ALU stub: sum modulo 16 regardless of sel.
  assign alu_out = alu_a + alu_b;

  always #5 clk = ~clk;

  alu_op_sequencer #(.WIDTH(4), .SEL_W(2), .SETTLE_CYCLES(SETTLE), .COUNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sel(cmd_sel), .cmd_chain(cmd_chain),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .busy(busy), .op_count(op_count)
  );

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] sel;
    logic       chain;
    logic [3:0] exp_a;
    logic [3:0] exp_res;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Present a command from IDLE (called at a negedge), check the ALU drive.
  task automatic start_cmd(input logic [3:0] a, input logic [3:0] b, input logic [1:0] sel,
                           input logic chain, input logic [3:0] exp_a, input string tag);
    cmd_a = a; cmd_b = b; cmd_sel = sel; cmd_chain = chain; cmd_valid = 1'b1;
    check({tag, "_cmd_ready"}, cmd_ready, 1);
    @(posedge clk); @(negedge clk);
    cmd_valid = 1'b0;
    check({tag, "_alu_a"}, alu_a, exp_a);
    check({tag, "_alu_b"}, alu_b, b);
    check({tag, "_alu_sel"}, alu_sel, sel);
    check({tag, "_busy"}, busy, 1);
  endtask

  // Wait (bounded) for res_valid after an accept; check latency and data.
  task automatic wait_res(input logic [3:0] exp_res, input string tag);
    int n = 0;
    while (!res_valid && n < 20) begin
      @(posedge clk); @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, n, SETTLE);
    check({tag, "_res_data"}, res_data, exp_res);
  endtask

  // Consume the pending result with no follow-on command.
  task automatic consume(input string tag);
    res_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    res_ready = 1'b0;
    exp_count = exp_count + 8'd1;
    check({tag, "_op_count"}, op_count, exp_count);
    check({tag, "_res_valid_clr"}, res_valid, 0);
    check({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    vecs[0] = '{4'b0111, 4'b0001, 2'b10, 1'b0, 4'b0111, 4'b1000};
    vecs[1] = '{4'b0101, 4'b0011, 2'b01, 1'b0, 4'b0101, 4'b1000};
    vecs[2] = '{4'b1010, 4'b0110, 2'b11, 1'b1, 4'b1000, 4'b1110};
    vecs[3] = '{4'b1111, 4'b0001, 2'b00, 1'b0, 4'b1111, 4'b0000};
    vecs[4] = '{4'b1001, 4'b0100, 2'b01, 1'b1, 4'b0000, 4'b0100};
    vecs[5] = '{4'b1100, 4'b0011, 2'b10, 1'b0, 4'b1100, 4'b1111};
    vecs[6] = '{4'b0101, 4'b0001, 2'b11, 1'b1, 4'b1111, 4'b0000};

    // Reset state.
    @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_op_count", op_count, 0);
    rst = 1'b0;
    #1;
    check("rel_cmd_ready", cmd_ready, 1);
    check("rel_busy", busy, 0);

    // Table-driven single ops.
    for (int i = 0; i < 7; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      start_cmd(vecs[i].a, vecs[i].b, vecs[i].sel, vecs[i].chain, vecs[i].exp_a, tag);
      wait_res(vecs[i].exp_res, tag);
      consume(tag);
    end

    // Backpressure: result held, no accept, ALU drive frozen.
    start_cmd(4'b0010, 4'b0011, 2'b01, 1'b0, 4'b0010, "bp");
    wait_res(4'b0101, "bp");
    cmd_a = 4'b1110; cmd_b = 4'b0001; cmd_sel = 2'b11; cmd_chain = 1'b1; cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); @(negedge clk);
      check("bp_hold_valid", res_valid, 1);
      check("bp_hold_data", res_data, 4'b0101);
      check("bp_hold_ready", cmd_ready, 0);
      check("bp_hold_alu_a", alu_a, 4'b0010);
      check("bp_hold_alu_sel", alu_sel, 2'b01);
    end
    res_ready = 1'b1;
    #1;
    check("bp_ready_follows", cmd_ready, 1);
    @(posedge clk); @(negedge clk);
    cmd_valid = 1'b0; res_ready = 1'b0;
    exp_count = exp_count + 8'd1;
    check("bp_handoff_count", op_count, exp_count);
    check("bp_chain_alu_a", alu_a, 4'b0101);
    check("bp_chain_alu_b", alu_b, 4'b0001);
    check("bp_chain_alu_sel", alu_sel, 2'b11);
    wait_res(4'b0110, "bp2");
    consume("bp2");

    // Back-to-back chain with the handoff in the same cycle.
    start_cmd(4'b0101, 4'b0011, 2'b00, 1'b0, 4'b0101, "b2b");
    wait_res(4'b1000, "b2b");
    cmd_a = 4'b0000; cmd_b = 4'b0110; cmd_sel = 2'b10; cmd_chain = 1'b1;
    cmd_valid = 1'b1; res_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    cmd_valid = 1'b0; res_ready = 1'b0;
    exp_count = exp_count + 8'd1;
    check("b2b_count", op_count, exp_count);
    check("b2b_alu_a", alu_a, 4'b1000);
    wait_res(4'b1110, "b2b2");
    consume("b2b2");

    // Counter wrap: stream ops until op_count returns to 0.
    begin
      int need, handled, cyc;
      need = 256 - int'(exp_count);
      handled = 0; cyc = 0;
      cmd_a = 4'b0001; cmd_b = 4'b0001; cmd_sel = 2'b00; cmd_chain = 1'b0;
      cmd_valid = 1'b1; res_ready = 1'b1;
      while (handled < need && cyc < 4000) begin
        if (res_valid) begin
          handled++;
          exp_count = exp_count + 8'd1;
          if (handled == need) cmd_valid = 1'b0;
        end
        @(posedge clk); @(negedge clk);
        cyc++;
      end
      res_ready = 1'b0;
      check("wrap_handled", handled, need);
      check("wrap_op_count", op_count, 8'd0);
      check("wrap_idle", busy, 0);
    end

    // Reset mid-operation: op dropped, chain then uses 0.
    start_cmd(4'b0011, 4'b0100, 2'b01, 1'b0, 4'b0011, "mid");
    #2 rst = 1'b1;
    #1;
    check("mid_async_alu_a", alu_a, 0);
    check("mid_async_busy", busy, 0);
    check("mid_async_ready", cmd_ready, 0);
    check("mid_async_valid", res_valid, 0);
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    exp_count = 8'd0;
    @(posedge clk); @(negedge clk);
    check("mid_no_result", res_valid, 0);
    check("mid_idle", busy, 0);
    start_cmd(4'b1111, 4'b0011, 2'b10, 1'b1, 4'b0000, "post");
    wait_res(4'b0011, "post");
    consume("post");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
